joystick_conditioner: RTL
=========================

// Module: joystick_conditioner
// PURPOSE
//   Front end between raw joystick pins and paddle logic: synchronises, debounces and arbitrates two
//   active-low direction buttons. Emits clean active-low control_up/control_down (1 = idle) that
//   feed the paddle's control inputs, plus one-cycle press pulses for menu/serve logic.
//   One instance per player.
// PARAMETERS
//   SYNC_STAGES      2       flops in input synchroniser (>=2)
//   DEBOUNCE_CYCLES  250000  stable cycles to accept a level change (5 ms @ 50 MHz), >=2
//   CNT_W            18      debounce counter width; 2**CNT_W > DEBOUNCE_CYCLES
//   STUCK_CYCLES     24'd15000000  continuous-press limit (300 ms), used only with JOY_STUCK_DETECT_EN
// PORTS
//   clock         in   1  system clock
//   reset         in   1  asynchronous, active-low reset
//   enable        in   1  1 = outputs live; 0 = outputs forced idle, FSMs keep tracking pins
//   btn_up_n      in   1  raw up pin, active-low, asynchronous to clock
//   btn_down_n    in   1  raw down pin, active-low, asynchronous to clock
//   control_up    out  1  debounced up, active-low (0 = move up)
//   control_down  out  1  debounced down, active-low (0 = move down)
//   up_press      out  1  1-cycle pulse on accepted up press
//   down_press    out  1  1-cycle pulse on accepted down press
//   stuck         out  1  1 while either channel is locked out (0 when feature compiled out)
// BEHAVIOUR
//   - Reset (reset=0, async): sync flops=1, states=IDLE, counters=0, control_*=1, *_press=0, stuck=0.
//   - Per-channel FSM on synchronised level s (0 = pressed):
//     IDLE     : s=0 -> PRESS_WAIT, cnt=0.
//     PRESS_WAIT: s=1 -> IDLE; else cnt++; cnt==DEBOUNCE_CYCLES-1 -> PRESSED, press pulse 1 cycle.
//     PRESSED  : s=1 -> RELEASE_WAIT, cnt=0.
//     RELEASE_WAIT: s=0 -> PRESSED (no new pulse); else cnt++; cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//   - Latency: a clean edge on a pin changes control_* exactly SYNC_STAGES+DEBOUNCE_CYCLES clocks
//     after the first clock edge that samples the new level. Glitches shorter than DEBOUNCE_CYCLES
//     (post-sync) never reach outputs.
//   - Counters saturate; never wrap. Compare is cnt==DEBOUNCE_CYCLES-1 on CNT_W bits.
//   - Raw debounced value d_* = (state in PRESSED or RELEASE_WAIT).
//   - Arbitration: both d_up and d_down active -> both control_* = 1 (paddle holds). Single active ->
//     that control = 0. Registered outputs, 1-cycle after FSM state update.
//   - Press pulses are not suppressed by arbitration; both may pulse in the same cycle.
//   - enable=0: control_*=1, *_press=0; FSMs/counters continue, so on enable rise outputs reflect
//     current debounced state the next cycle with no spurious press pulse.
//   - Reset mid-debounce: all progress discarded; a still-held button re-debounces from IDLE.
// CONFIGURATION
//   JOY_STUCK_DETECT_EN defined: extra state LOCKED. PRESSED/RELEASE_WAIT time accumulates in a
//     24-bit hold counter; reaching STUCK_CYCLES -> LOCKED: channel output idle (1), stuck=1.
//     LOCKED -> IDLE only after s=1 for DEBOUNCE_CYCLES; hold counter cleared on every IDLE entry.
//   Undefined: no LOCKED state, no hold counter, stuck tied 0; a held button drives output forever.
// STRUCTURE
//   Shared package pong_pkg: channel state encoding (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT,
//     LOCKED), CTRL_ACTIVE=1'b0 / CTRL_IDLE=1'b1 constants reused by paddle.
//   Sub-module debounce_channel (sync chain + FSM + counters + optional lockout), instantiated
//     twice; top holds arbitration, enable gating and output registers.
// TESTING (bench: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STUCK_CYCLES=20)
//   1. Reset: reset=0 with btn_up_n=0 -> control_up=1, up_press=0; release reset -> control_up=0
//      7 clocks later (2 sync + 4 debounce + 1 output reg), up_press high exactly 1 cycle.
//   2. Glitch: btn_down_n low for 3 cycles then high -> control_down stays 1, down_press never 1.
//   3. Release bounce: held up, pin high 2 cycles then low -> control_up stays 0, no second pulse.
//   4. Conflict: up accepted, then down accepted -> both outputs 1; release down -> control_up=0
//      6 clocks after release sampled.
//   5. Enable: both pins idle, enable=0, press up 10 cycles, enable=1 -> control_up=0 next cycle,
//      up_press=0 throughout.
//   6. JOY_STUCK_DETECT_EN: hold up 30 cycles -> control_up returns 1, stuck=1 after 20 held cycles;
//      release 4 cycles -> stuck=0; new press accepted normally.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared pong types: per-channel debounce state encoding, paddle control levels, channel status.
// LOCKED is only reachable when built with JOY_STUCK_DETECT_EN.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT,
        ST_LOCKED
    } chan_state_t;

    // Paddle control inputs are active-low: 1 means "no movement requested".
    localparam logic CTRL_ACTIVE = 1'b0;
    localparam logic CTRL_IDLE   = 1'b1;

    localparam int NUM_CH  = 2;
    localparam int CH_UP   = 0;
    localparam int CH_DOWN = 1;

    typedef struct packed {
        logic deb;     // debounced level, 1 = pressed
        logic press;   // one-cycle pulse on accepted press
        logic locked;  // channel in stuck lockout
    } chan_stat_t;

    function automatic logic ctrl_level(input logic active);
        return active ? CTRL_ACTIVE : CTRL_IDLE;
    endfunction

endpackage

// File: rtl/joystick_conditioner_if.sv
// Pin/control bundle between the board joystick pins, one conditioner and the paddle logic.
interface joystick_conditioner_if;

    logic enable;
    logic btn_up_n;
    logic btn_down_n;
    logic control_up;
    logic control_down;
    logic up_press;
    logic down_press;
    logic stuck;

    modport master (
        output enable, btn_up_n, btn_down_n,
        input  control_up, control_down, up_press, down_press, stuck
    );

    modport slave (
        input  enable, btn_up_n, btn_down_n,
        output control_up, control_down, up_press, down_press, stuck
    );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, debounce FSM with saturating counter, press pulse.
// JOY_STUCK_DETECT_EN adds a hold counter that locks the channel out after STUCK_CYCLES held.
module debounce_channel
    import pong_pkg::*;
#(
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          CNT_W           = 18,
    parameter logic [23:0] STUCK_CYCLES    = 24'd15000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pin_n,
    output chan_stat_t stat
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    chan_state_t            state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   press;
    logic                   deb;

    assign s       = sync[SYNC_STAGES-1];
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    assign deb     = (state == ST_PRESSED) || (state == ST_RELEASE_WAIT);

`ifdef JOY_STUCK_DETECT_EN
    logic [23:0] hold;
    logic [23:0] hold_inc;

    assign hold_inc = (hold == '1) ? hold : hold + 1'b1;
`else
    logic unused_stuck_cfg;

    assign unused_stuck_cfg = ^STUCK_CYCLES;
`endif

    // The sample that moves IDLE->PRESS_WAIT counts as the first stable one,
    // so the wait states finish when the incremented count reaches LAST.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync  <= '1;
            state <= ST_IDLE;
            cnt   <= '0;
            press <= 1'b0;
`ifdef JOY_STUCK_DETECT_EN
            hold  <= '0;
`endif
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], pin_n};
            press <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!s) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (s) begin
                        state <= ST_IDLE;
                    end else if (cnt_inc == LAST) begin
                        state <= ST_PRESSED;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (s) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (!s) begin
                        state <= ST_PRESSED;
                    end else if (cnt_inc == LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
`ifdef JOY_STUCK_DETECT_EN
                // Lockout clears only after DEBOUNCE_CYCLES of released samples.
                ST_LOCKED: begin
                    if (!s) begin
                        cnt <= '0;
                    end else if (cnt == LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
`ifdef JOY_STUCK_DETECT_EN
            // Placed after the case so a lockout overrides that cycle's transition.
            if (state == ST_IDLE) begin
                hold <= '0;
            end else if (deb) begin
                hold <= hold_inc;
                if (hold_inc == STUCK_CYCLES) begin
                    state <= ST_LOCKED;
                    cnt   <= '0;
                end
            end
`endif
        end
    end

`ifdef JOY_STUCK_DETECT_EN
    assign stat = '{deb: deb, press: press, locked: (state == ST_LOCKED)};
`else
    assign stat = '{deb: deb, press: press, locked: 1'b0};
`endif

endmodule

// File: rtl/joystick_conditioner.sv
// Per-player joystick front end: two debounce channels, up/down arbitration, enable gating.
// Optional stuck-button lockout is built in with JOY_STUCK_DETECT_EN.
module joystick_conditioner
    import pong_pkg::*;
#(
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter int          CNT_W           = 18,
    parameter logic [23:0] STUCK_CYCLES    = 24'd15000000
) (
    input logic                   clock,
    input logic                   reset,
    joystick_conditioner_if.slave bus
);

    logic [NUM_CH-1:0]      pins;
    chan_stat_t [NUM_CH-1:0] stat;

    assign pins = {bus.btn_down_n, bus.btn_up_n};

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            debounce_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W),
                .STUCK_CYCLES   (STUCK_CYCLES)
            ) u_ch (
                .clock(clock),
                .reset(reset),
                .pin_n(pins[g]),
                .stat (stat[g])
            );
        end
    endgenerate

    logic ctrl_up;
    logic ctrl_down;
    logic up_press;
    logic down_press;
    logic stuck;

    // Both directions held means the paddle holds still; press pulses ignore arbitration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ctrl_up    <= CTRL_IDLE;
            ctrl_down  <= CTRL_IDLE;
            up_press   <= 1'b0;
            down_press <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            ctrl_up    <= ctrl_level(bus.enable && stat[CH_UP].deb && !stat[CH_DOWN].deb);
            ctrl_down  <= ctrl_level(bus.enable && stat[CH_DOWN].deb && !stat[CH_UP].deb);
            up_press   <= bus.enable && stat[CH_UP].press;
            down_press <= bus.enable && stat[CH_DOWN].press;
            stuck      <= stat[CH_UP].locked || stat[CH_DOWN].locked;
        end
    end

    assign bus.control_up   = ctrl_up;
    assign bus.control_down = ctrl_down;
    assign bus.up_press     = up_press;
    assign bus.down_press   = down_press;
    assign bus.stuck        = stuck;

endmodule
